// File: rtl/key_conditioner.sv
// Board-level key/switch conditioner and core reset sequencer.
// Optional macro KEYCOND_SOFT_RESET_EN: KEY[3] press restarts the core reset hold.
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES   = 1000,
    parameter int unsigned RESET_HOLD_CYCLES = 16
) (
    input  logic       clk50,
    input  logic       reset_n,
    input  logic [2:0] keys_raw,
    input  logic [9:0] sw_raw,
    output logic       core_rst_n,
    output logic [2:0] key_level,
    output logic [2:0] key_press,
    output logic [9:0] sw_sync
);

    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  HOLD_LAST = 8'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        S_ASSERT = 2'd0,
        S_HOLD   = 2'd1,
        S_RUN    = 2'd2
    } seq_e;

    logic [1:0]       rst_sync_q, rst_sync_d;
    logic             rst_int_n;

    seq_e             state_q, state_d;
    logic [7:0]       hold_cnt_q, hold_cnt_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             soft_rst;

    logic [2:0]       key_meta_q, key_meta_d;
    logic [2:0]       key_sync_q, key_sync_d;
    logic [2:0]       level_q, level_d;
    logic [2:0]       level_dly_q, level_dly_d;
    logic [2:0]       press_q, press_d;
    logic [2:0][15:0] db_cnt_q, db_cnt_d;

    logic [9:0]       sw_meta_q, sw_meta_d;
    logic [9:0]       sw_sync_q, sw_sync_d;

    // Release synchronizer: assertion is immediate, release takes two edges.
    assign rst_sync_d = {rst_sync_q[0], 1'b1};
    assign rst_int_n  = rst_sync_q[1];

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= rst_sync_d;
        end
    end

`ifdef KEYCOND_SOFT_RESET_EN
    assign soft_rst = press_q[2];
`else
    assign soft_rst = 1'b0;
`endif

    // The state register acts as the second stage for the release:
    // it only leaves ASSERT once the first sync stage has seen reset_n high.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        unique case (state_q)
            S_ASSERT: begin
                if (rst_sync_q[0]) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            S_HOLD: begin
                if (soft_rst) begin
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = S_RUN;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            S_RUN: begin
                if (soft_rst) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_ASSERT;
                hold_cnt_d = '0;
            end
        endcase
        core_rst_n_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_ASSERT;
            hold_cnt_q   <= '0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    // Keys are inverted on entry so a cleared synchronizer means "released".
    always_comb begin
        key_meta_d  = ~keys_raw;
        key_sync_d  = key_meta_q;
        sw_meta_d   = sw_raw;
        sw_sync_d   = sw_meta_q;
        level_d     = level_q;
        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (key_sync_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = key_sync_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk50 or negedge rst_int_n) begin
        if (!rst_int_n) begin
            key_meta_q  <= '0;
            key_sync_q  <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            press_q     <= '0;
            db_cnt_q    <= '0;
            sw_meta_q   <= '0;
            sw_sync_q   <= '0;
        end else begin
            key_meta_q  <= key_meta_d;
            key_sync_q  <= key_sync_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            db_cnt_q    <= db_cnt_d;
            sw_meta_q   <= sw_meta_d;
            sw_sync_q   <= sw_sync_d;
        end
    end

    assign core_rst_n = core_rst_n_q;
    assign key_level  = level_q;
    assign key_press  = press_q;
    assign sw_sync    = sw_sync_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner (DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8).
// Cycle n below means the interval just after the n-th rising edge.
module tb_key_conditioner;

    logic       clk50;
    logic       reset_n;
    logic [2:0] keys_raw;
    logic [9:0] sw_raw;
    logic       core_rst_n;
    logic [2:0] key_level;
    logic [2:0] key_press;
    logic [9:0] sw_sync;

    int vectors     = 0;
    int miscompares = 0;

    key_conditioner #(
        .DEBOUNCE_CYCLES  (4),
        .RESET_HOLD_CYCLES(8)
    ) dut (
        .clk50     (clk50),
        .reset_n   (reset_n),
        .keys_raw  (keys_raw),
        .sw_raw    (sw_raw),
        .core_rst_n(core_rst_n),
        .key_level (key_level),
        .key_press (key_press),
        .sw_sync   (sw_sync)
    );

    initial begin
        clk50 = 1'b0;
        forever #10 clk50 = ~clk50;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk50);
        #1;
    endtask

    initial begin
        logic [15:0] exp_core;
        reset_n  = 1'b0;
        keys_raw = 3'b111;
        sw_raw   = 10'h3FF;

        // Reset state, switches driven high must not leak through
        @(posedge clk50);
        #5;
        check("rst_core", 16'(core_rst_n), 16'd0);
        check("rst_level", 16'(key_level), 16'd0);
        check("rst_press", 16'(key_press), 16'd0);
        check("rst_sw", 16'(sw_sync), 16'd0);
        sw_raw = 10'h000;
        @(negedge clk50);
        reset_n = 1'b1;

        // Release: core_rst_n low through cycle 9, high from cycle 10
        for (int n = 1; n <= 12; n++) begin
            step();
            check("rel_core", 16'(core_rst_n), 16'(n >= 10));
        end
        check("rel_level", 16'(key_level), 16'd0);
        check("rel_press", 16'(key_press), 16'd0);
        check("rel_sw", 16'(sw_sync), 16'd0);

        // KEY[1] clean press held 10 cycles
        repeat (3) step();
        keys_raw[0] = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            step();
            check("k0_level", 16'(key_level[0]), 16'(n >= 6));
            check("k0_press", 16'(key_press[0]), 16'(n == 7));
        end
        keys_raw[0] = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            check("k0_rel_level", 16'(key_level[0]), 16'(n < 6));
            check("k0_rel_press", 16'(key_press), 16'd0);
        end

        // KEY[2] 3-cycle glitch is rejected
        keys_raw[1] = 1'b0;
        for (int n = 1; n <= 11; n++) begin
            step();
            if (n == 3) keys_raw[1] = 1'b1;
            check("glitch3_level", 16'(key_level[1]), 16'd0);
            check("glitch3_press", 16'(key_press[1]), 16'd0);
        end

        // KEY[2] 4-cycle pulse is exactly long enough
        keys_raw[1] = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (n == 4) keys_raw[1] = 1'b1;
            check("pulse4_level", 16'(key_level[1]), 16'(n >= 6 && n <= 9));
            check("pulse4_press", 16'(key_press[1]), 16'(n == 7));
        end
        repeat (4) step();

        // KEY[1] and KEY[3] together; KEY[3] soft reset when enabled
        keys_raw = 3'b010;
        for (int n = 1; n <= 18; n++) begin
            step();
            if (n == 10) keys_raw = 3'b111;
            check("dual_level", 16'(key_level),
                  (n >= 6 && n < 16) ? 16'h5 : 16'h0);
            check("dual_press", 16'(key_press),
                  (n == 7) ? 16'h5 : 16'h0);
`ifdef KEYCOND_SOFT_RESET_EN
            exp_core = 16'(!(n >= 8 && n <= 15));
`else
            exp_core = 16'd1;
`endif
            check("soft_core", 16'(core_rst_n), exp_core);
        end
        repeat (4) step();

        // Switch synchronizer latency
        sw_raw = 10'h2A5;
        step();
        check("sw_lat1", 16'(sw_sync), 16'h000);
        step();
        check("sw_lat2", 16'(sw_sync), 16'h2A5);

        // Reset aborted mid-HOLD, with KEY[1] held through it
        keys_raw[0] = 1'b0;
        @(negedge clk50);
        reset_n = 1'b0;
        @(posedge clk50);
        @(negedge clk50);
        reset_n = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            check("hold_core", 16'(core_rst_n), 16'd0);
        end
        reset_n = 1'b0;
        #1;
        check("abort_core", 16'(core_rst_n), 16'd0);
        check("abort_level", 16'(key_level), 16'd0);
        check("abort_press", 16'(key_press), 16'd0);
        check("abort_sw", 16'(sw_sync), 16'd0);
        @(negedge clk50);
        @(posedge clk50);
        @(negedge clk50);
        reset_n = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            step();
            check("rerun_core", 16'(core_rst_n), 16'(n >= 10));
            check("held_level", 16'(key_level[0]), 16'(n >= 8));
            check("held_press", 16'(key_press[0]), 16'(n == 9));
        end
        check("rerun_sw", 16'(sw_sync), 16'h2A5);
        keys_raw = 3'b111;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
